rob_commit_buffer: RTL and testbench

// Entry storage and in-order commit stage of the reorder buffer; sits directly downstream of the head/tail

---
 rtl/rob_commit_buffer.sv | 176 +++++++++++++++++
 tb/tb_rob_commit_buffer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_buffer.sv
// ----------------------------------------------------------------------------
// rob_commit_buffer
//
// Entry storage and in-order commit stage of the reorder buffer. It sits
// directly downstream of the head/tail pointer block. It does the following:
//   - captures dispatched entries at the index the pointer block allocates
//   - marks entries done on writeback and stores their result data
//   - retires the entry at the pointer block's head index to the register
//     file, strictly in program order, at most one per cycle
//   - pulses updateHead_o on every retirement so the pointer block can
//     advance its head
// This block keeps no pointers of its own. Indices arrive from the pointer
// block already reduced modulo ROBsize.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_i        asynchronous, active-high reset
//   alloc_i        dispatch allocates one entry this cycle
//   alloc_idx_i    entry index to allocate (pointer block tail)
//   alloc_dest_i   destination register of the allocated entry
//   alloc_wen_i    allocated entry writes the register file on commit
//   stall_i        pointer block full; alloc_i is ignored while high
//   wb_valid_i     writeback of a completed result
//   wb_idx_i       entry index being written back
//   wb_data_i      result data
//   head_i         current head index from the pointer block
//   flush_i        synchronous squash of all entries
//   commit_ready_i register file accepts a commit this cycle
//   commit_valid_o head entry is valid and done
//   commit_dest_o  head entry destination (0 when commit_valid_o=0)
//   commit_data_o  head entry result (0 when commit_valid_o=0)
//   commit_wen_o   head entry write enable (0 when commit_valid_o=0)
//   updateHead_o   head-advance pulse, asserted in the cycle a commit fires
//   count_o        number of valid entries
//   wb_err_o       sticky writeback/allocation protocol error flag
// ----------------------------------------------------------------------------
module rob_commit_buffer #(
   parameter int unsigned ROBsize  = 32,
   parameter int unsigned addrSize = $clog2(ROBsize),
   parameter int unsigned REGW     = 5,
   parameter int unsigned DATAW    = 64
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                alloc_i,
   input  logic [addrSize-1:0] alloc_idx_i,
   input  logic [REGW-1:0]     alloc_dest_i,
   input  logic                alloc_wen_i,
   input  logic                stall_i,
   input  logic                wb_valid_i,
   input  logic [addrSize-1:0] wb_idx_i,
   input  logic [DATAW-1:0]    wb_data_i,
   input  logic [addrSize-1:0] head_i,
   input  logic                flush_i,
   input  logic                commit_ready_i,
   output logic                commit_valid_o,
   output logic [REGW-1:0]     commit_dest_o,
   output logic [DATAW-1:0]    commit_data_o,
   output logic                commit_wen_o,
   output logic                updateHead_o,
   output logic [addrSize:0]   count_o,
   output logic                wb_err_o
);

   // Per-entry state. Only valid/done need reset. Payload fields are never
   // observed unless the entry is valid (and done, for data).
   logic [ROBsize-1:0] r_valid;
   logic [ROBsize-1:0] r_done;
   logic [REGW-1:0]    r_dest [ROBsize];
   logic               r_wen  [ROBsize];
   logic [DATAW-1:0]   r_data [ROBsize];
   logic [addrSize:0]  r_count;
   logic               r_wb_err;

   logic               w_head_ready;
   logic               w_fire;
   logic               w_alloc_req;
   logic               w_alloc_busy;
   logic               w_alloc_ok;
   logic               w_alloc_err;
   logic               w_wb_req;
   logic               w_wb_ok;
   logic               w_wb_err;
   logic [addrSize:0]  w_count_next;

   // Commit: the head entry is presented as soon as it is valid and done.
   // Both bits are registered, so there is no writeback-to-commit bypass.
   always_comb begin
      w_head_ready = r_valid[head_i] & r_done[head_i];
      w_fire       = w_head_ready & commit_ready_i & ~flush_i;
   end

   // Allocation is refused when the target entry is still live. The one
   // exception is the full-wrap case: the same entry retires this cycle, so
   // the slot frees at the same edge.
   always_comb begin
      w_alloc_req  = alloc_i & ~stall_i & ~flush_i;
      w_alloc_busy = r_valid[alloc_idx_i] & ~(w_fire & (alloc_idx_i == head_i));
      w_alloc_ok   = w_alloc_req & ~w_alloc_busy;
      w_alloc_err  = w_alloc_req & w_alloc_busy;
   end

   // Writeback must target an entry that was already live before this edge
   // and is not retiring at it. Writebacks to a same-cycle allocation or to
   // the committing entry are therefore refused and counted as errors.
   always_comb begin
      w_wb_req = wb_valid_i & ~flush_i;
      w_wb_ok  = w_wb_req & r_valid[wb_idx_i] & ~(w_fire & (wb_idx_i == head_i));
      w_wb_err = w_wb_req & ~w_wb_ok;
   end

   always_comb begin
      w_count_next = r_count
                   + {{addrSize{1'b0}}, w_alloc_ok}
                   - {{addrSize{1'b0}}, w_fire};
   end

   // The fire clear is written before the alloc set, so on a full wrap the
   // later assignment leaves the entry valid with done=0.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_valid  <= '0;
         r_done   <= '0;
         r_count  <= '0;
         r_wb_err <= 1'b0;
      end else if (flush_i) begin
         r_valid  <= '0;
         r_done   <= '0;
         r_count  <= '0;
      end else begin
         if (w_fire) begin
            r_valid[head_i] <= 1'b0;
            r_done[head_i]  <= 1'b0;
         end
         if (w_alloc_ok) begin
            r_valid[alloc_idx_i] <= 1'b1;
            r_done[alloc_idx_i]  <= 1'b0;
         end
         if (w_wb_ok) begin
            r_done[wb_idx_i] <= 1'b1;
         end
         r_count <= w_count_next;
         if (w_alloc_err | w_wb_err) begin
            r_wb_err <= 1'b1;
         end
      end
   end

   // Payload capture. The enables are already qualified by flush and by
   // the entry state, so reset is not needed here.
   always_ff @(posedge clk_i) begin
      if (w_alloc_ok) begin
         r_dest[alloc_idx_i] <= alloc_dest_i;
         r_wen[alloc_idx_i]  <= alloc_wen_i;
      end
      if (w_wb_ok) begin
         r_data[wb_idx_i] <= wb_data_i;
      end
   end

   always_comb begin
      commit_valid_o = w_head_ready;
      commit_dest_o  = '0;
      commit_data_o  = '0;
      commit_wen_o   = 1'b0;
      if (w_head_ready) begin
         commit_dest_o = r_dest[head_i];
         commit_data_o = r_data[head_i];
         commit_wen_o  = r_wen[head_i];
      end
      updateHead_o = w_fire;
      count_o      = r_count;
      wb_err_o     = r_wb_err;
   end

endmodule

// File: tb/tb_rob_commit_buffer.sv
// ----------------------------------------------------------------------------
// tb_rob_commit_buffer
//
// Directed bench for rob_commit_buffer. When an allocation is driven, the
// expected commit (index, destination, write enable) is queued. Result data
// is recorded per index when the writeback is driven. Each commit the DUT
// presents is popped from the queue and compared.
// ----------------------------------------------------------------------------
module tb_rob_commit_buffer;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        alloc_i;
   logic [4:0]  alloc_idx_i;
   logic [4:0]  alloc_dest_i;
   logic        alloc_wen_i;
   logic        stall_i;
   logic        wb_valid_i;
   logic [4:0]  wb_idx_i;
   logic [63:0] wb_data_i;
   logic [4:0]  head_i;
   logic        flush_i;
   logic        commit_ready_i;
   logic        commit_valid_o;
   logic [4:0]  commit_dest_o;
   logic [63:0] commit_data_o;
   logic        commit_wen_o;
   logic        updateHead_o;
   logic [5:0]  count_o;
   logic        wb_err_o;

   typedef struct {
      logic [4:0] idx;
      logic [4:0] dest;
      logic       wen;
   } sb_t;

   sb_t         sb[$];
   logic [63:0] dmem [32];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   rob_commit_buffer #(
      .ROBsize (32),
      .REGW    (5),
      .DATAW   (64)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .alloc_i        (alloc_i),
      .alloc_idx_i    (alloc_idx_i),
      .alloc_dest_i   (alloc_dest_i),
      .alloc_wen_i    (alloc_wen_i),
      .stall_i        (stall_i),
      .wb_valid_i     (wb_valid_i),
      .wb_idx_i       (wb_idx_i),
      .wb_data_i      (wb_data_i),
      .head_i         (head_i),
      .flush_i        (flush_i),
      .commit_ready_i (commit_ready_i),
      .commit_valid_o (commit_valid_o),
      .commit_dest_o  (commit_dest_o),
      .commit_data_o  (commit_data_o),
      .commit_wen_o   (commit_wen_o),
      .updateHead_o   (updateHead_o),
      .count_o        (count_o),
      .wb_err_o       (wb_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      alloc_i        = 1'b0;
      alloc_idx_i    = '0;
      alloc_dest_i   = '0;
      alloc_wen_i    = 1'b0;
      stall_i        = 1'b0;
      wb_valid_i     = 1'b0;
      wb_idx_i       = '0;
      wb_data_i      = '0;
      flush_i        = 1'b0;
      commit_ready_i = 1'b0;
   endtask

   task automatic drive_alloc(input logic [4:0] idx, input logic [4:0] dest, input logic wen);
      sb_t e;
      alloc_i      = 1'b1;
      alloc_idx_i  = idx;
      alloc_dest_i = dest;
      alloc_wen_i  = wen;
      e.idx  = idx;
      e.dest = dest;
      e.wen  = wen;
      sb.push_back(e);
   endtask

   task automatic drive_wb(input logic [4:0] idx, input logic [63:0] data);
      wb_valid_i = 1'b1;
      wb_idx_i   = idx;
      wb_data_i  = data;
      dmem[idx]  = data;
   endtask

   // The commit presented now must be the oldest outstanding allocation.
   task automatic chk_fire(input string tag);
      sb_t e;
      chk({tag, "_valid"}, commit_valid_o, 1'b1);
      chk({tag, "_updHead"}, updateHead_o, 1'b1);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s_sb observed=commit expected=no_commit", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_idx"}, head_i, e.idx);
         chk({tag, "_dest"}, commit_dest_o, e.dest);
         chk({tag, "_data"}, commit_data_o, dmem[e.idx]);
         chk({tag, "_wen"}, commit_wen_o, e.wen);
      end
   endtask

   initial begin
      idle();
      head_i  = '0;
      reset_i = 1'b1;
      for (int i = 0; i < 32; i++) dmem[i] = '0;
      #1;
      chk("rst_count", count_o, 0);
      chk("rst_valid", commit_valid_o, 0);
      chk("rst_updHead", updateHead_o, 0);
      chk("rst_err", wb_err_o, 0);
      chk("rst_dest", commit_dest_o, 0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      tick();

      // 1: out-of-order writeback, in-order commit
      drive_alloc(5'd0, 5'd3, 1'b1); tick();
      drive_alloc(5'd1, 5'd4, 1'b1); tick();
      drive_alloc(5'd2, 5'd5, 1'b1); tick();
      idle(); #1;
      chk("t1_count3", count_o, 3);
      chk("t1_notdone", commit_valid_o, 0);
      drive_wb(5'd2, 64'hA2); #1;
      chk("t1_wb2_nocommit", commit_valid_o, 0);
      tick();
      idle(); drive_wb(5'd0, 64'hA0); #1;
      chk("t1_wb0_nobypass", commit_valid_o, 0);
      tick();
      idle(); drive_wb(5'd1, 64'hA1); commit_ready_i = 1'b1; #1;
      chk_fire("t1_c0");
      tick();
      idle(); commit_ready_i = 1'b1; head_i = 5'd1; #1;
      chk_fire("t1_c1");
      tick();
      head_i = 5'd2; #1;
      chk_fire("t1_c2");
      tick();
      head_i = 5'd3; #1;
      chk("t1_end_updHead", updateHead_o, 0);
      chk("t1_end_valid", commit_valid_o, 0);
      chk("t1_end_dest", commit_dest_o, 0);
      chk("t1_end_count", count_o, 0);

      // 2: backpressure holds the head entry
      idle(); drive_alloc(5'd3, 5'd6, 1'b0); tick();
      idle(); drive_wb(5'd3, 64'hB3); tick();
      idle();
      for (int unsigned k = 0; k < 4; k++) begin
         #1;
         chk("t2_hold_valid", commit_valid_o, 1);
         chk("t2_hold_dest", commit_dest_o, 6);
         chk("t2_hold_data", commit_data_o, 64'hB3);
         chk("t2_hold_wen", commit_wen_o, 0);
         chk("t2_hold_updHead", updateHead_o, 0);
         tick();
      end
      commit_ready_i = 1'b1; #1;
      chk_fire("t2_c3");
      tick();
      head_i = 5'd4; #1;
      chk("t2_single_pulse", updateHead_o, 0);
      chk("t2_count", count_o, 0);

      // 3: fill, stalled alloc, then commit+alloc of the same index
      idle();
      for (int unsigned i = 0; i < 32; i++) begin
         drive_alloc(5'((4 + i) % 32), 5'(i), 1'b1);
         tick();
      end
      idle(); #1;
      chk("t3_full", count_o, 32);
      alloc_i = 1'b1; stall_i = 1'b1; alloc_idx_i = 5'd4; alloc_dest_i = 5'd31; alloc_wen_i = 1'b1;
      tick();
      idle(); #1;
      chk("t3_stall_count", count_o, 32);
      chk("t3_stall_noerr", wb_err_o, 0);
      drive_wb(5'd4, 64'hC4); tick();
      idle();
      alloc_i = 1'b1; alloc_idx_i = 5'd4; alloc_dest_i = 5'd9; alloc_wen_i = 1'b1;
      commit_ready_i = 1'b1; #1;
      chk_fire("t3_wrap");
      tick();
      idle(); #1;
      chk("t3_wrap_count", count_o, 32);
      chk("t3_wrap_notdone", commit_valid_o, 0);
      chk("t3_wrap_noerr", wb_err_o, 0);
      drive_wb(5'd4, 64'hD4); tick();
      idle(); #1;
      chk("t3_new_valid", commit_valid_o, 1);
      chk("t3_new_dest", commit_dest_o, 9);
      chk("t3_new_data", commit_data_o, 64'hD4);
      chk("t3_new_err", wb_err_o, 0);
      flush_i = 1'b1; tick();
      idle(); #1;
      chk("t3_flush_count", count_o, 0);
      chk("t3_flush_valid", commit_valid_o, 0);
      sb.delete();

      // 5: flush with concurrent alloc, writeback and ready commit
      head_i = 5'd10;
      for (int unsigned i = 0; i < 8; i++) begin
         drive_alloc(5'(10 + i), 5'(20 + i), 1'b1);
         tick();
      end
      idle();
      for (int unsigned i = 0; i < 3; i++) begin
         drive_wb(5'(10 + 2 * i), 64'hE0 + 64'(i));
         tick();
      end
      idle(); #1;
      chk("t5_count8", count_o, 8);
      chk("t5_head_done", commit_valid_o, 1);
      flush_i = 1'b1; alloc_i = 1'b1; alloc_idx_i = 5'd18; alloc_dest_i = 5'd1;
      wb_valid_i = 1'b1; wb_idx_i = 5'd11; wb_data_i = 64'h11; commit_ready_i = 1'b1; #1;
      chk("t5_flush_noupd", updateHead_o, 0);
      tick();
      idle(); #1;
      chk("t5_count0", count_o, 0);
      chk("t5_valid0", commit_valid_o, 0);
      chk("t5_err_kept0", wb_err_o, 0);
      sb.delete();

      // 4: writeback to an unallocated entry is a sticky error
      head_i = 5'd7;
      drive_wb(5'd7, 64'h77); tick();
      idle(); #1;
      chk("t4_count", count_o, 0);
      chk("t4_valid", commit_valid_o, 0);
      chk("t4_err", wb_err_o, 1);
      drive_alloc(5'd7, 5'd12, 1'b1); tick();
      idle(); drive_wb(5'd7, 64'hF7); tick();
      idle(); commit_ready_i = 1'b1; #1;
      chk_fire("t4_c7");
      tick();
      idle(); head_i = 5'd8; #1;
      chk("t4_err_sticky", wb_err_o, 1);
      chk("t4_count0", count_o, 0);

      // 6: asynchronous reset between edges
      drive_alloc(5'd8, 5'd13, 1'b1); tick();
      idle(); drive_alloc(5'd9, 5'd14, 1'b0); tick();
      idle(); drive_wb(5'd8, 64'h88); tick();
      idle(); drive_wb(5'd9, 64'h99); commit_ready_i = 1'b1; #1;
      chk_fire("t6_c8");
      tick();
      idle(); head_i = 5'd9; commit_ready_i = 1'b1; #1;
      chk("t6_pre_valid", commit_valid_o, 1);
      chk("t6_pre_updHead", updateHead_o, 1);
      #1;
      reset_i = 1'b1; #1;
      chk("t6_rst_valid", commit_valid_o, 0);
      chk("t6_rst_updHead", updateHead_o, 0);
      chk("t6_rst_count", count_o, 0);
      chk("t6_rst_err", wb_err_o, 0);
      sb.delete();
      tick();
      reset_i = 1'b0;
      tick();
      chk("t6_post_valid", commit_valid_o, 0);
      chk("t6_post_updHead", updateHead_o, 0);
      chk("t6_post_count", count_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Guards against a stalled simulation.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
